// File: rtl/alu_pkg.sv
// Shared types for the condition-check slice: ARM-style condition codes,
// flag bit positions inside the {N,Z,C,V} flag vector, and response-slot states.
package alu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM-style condition evaluator: (cond, {N,Z,C,V}) -> taken.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_taken
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_taken = 1'b0;
        case (cond_e'(i_cond))
            COND_EQ: o_taken = w_z;
            COND_NE: o_taken = !w_z;
            COND_CS: o_taken = w_c;
            COND_CC: o_taken = !w_c;
            COND_MI: o_taken = w_n;
            COND_PL: o_taken = !w_n;
            COND_VS: o_taken = w_v;
            COND_VC: o_taken = !w_v;
            COND_HI: o_taken = w_c & !w_z;
            COND_LS: o_taken = !w_c | w_z;
            COND_GE: o_taken = (w_n == w_v);
            COND_LT: o_taken = (w_n != w_v);
            COND_GT: o_taken = !w_z & (w_n == w_v);
            COND_LE: o_taken = w_z | (w_n != w_v);
            COND_AL: o_taken = 1'b1;
            COND_NV: o_taken = 1'b0;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_check_unit.sv
// Flag register + outstanding-compare tracker + condition query responder.
// Optional macro COND_BYPASS_EN lets a query evaluate against the flags arriving this cycle.
module cond_check_unit
    import alu_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmp_issue,
    output logic              o_cmp_ready,
    input  logic              i_flags_valid,
    input  logic              i_n,
    input  logic              i_z,
    input  logic              i_c,
    input  logic              i_v,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [3:0]        i_cond,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_taken,
    output logic [3:0]        o_flags,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_err
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [3:0]        r_flags;
    logic [PEND_W-1:0] r_pending;
    logic              r_err;
    logic              r_taken;
    slot_e             r_state;
    slot_e             w_state_next;

    logic [3:0] w_in_flags;
    logic [3:0] w_eval_flags;
    logic       w_pend_zero;
    logic       w_issue_acc;
    logic       w_flags_cnt;
    logic       w_slot_free;
    logic       w_req_ready;
    logic       w_accept;
    logic       w_eval_taken;

    assign w_in_flags  = {i_n, i_z, i_c, i_v};
    assign w_pend_zero = (r_pending == '0);
    assign w_issue_acc = i_cmp_issue & (r_pending != PEND_MAX);
    assign w_flags_cnt = i_flags_valid & !w_pend_zero;
    assign w_slot_free = (r_state == SLOT_EMPTY) | i_rsp_ready;

`ifdef COND_BYPASS_EN
    // Last in-flight compare landing now: answer from its flags instead of waiting a cycle.
    logic w_bypass;
    assign w_bypass     = (r_pending == PEND_W'(1)) & i_flags_valid & !i_cmp_issue;
    assign w_req_ready  = w_slot_free & (w_pend_zero | w_bypass);
    assign w_eval_flags = w_bypass ? w_in_flags : r_flags;
`else
    assign w_req_ready  = w_slot_free & w_pend_zero;
    assign w_eval_flags = r_flags;
`endif

    assign w_accept = i_req_valid & w_req_ready;

    cond_eval u_cond_eval (
        .i_cond  (i_cond),
        .i_flags (w_eval_flags),
        .o_taken (w_eval_taken)
    );

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = SLOT_FULL;
        end else if ((r_state == SLOT_FULL) && i_rsp_ready) begin
            w_state_next = SLOT_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= SLOT_EMPTY;
            r_taken   <= 1'b0;
            r_flags   <= 4'b0000;
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_taken <= w_eval_taken;
            end
            if (w_flags_cnt) begin
                r_flags <= w_in_flags;
            end
            if (w_issue_acc && !w_flags_cnt) begin
                r_pending <= r_pending + PEND_W'(1);
            end else if (!w_issue_acc && w_flags_cnt) begin
                r_pending <= r_pending - PEND_W'(1);
            end
            // A result with nothing outstanding is a protocol violation upstream.
            if (i_flags_valid && w_pend_zero) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_cmp_ready = (r_pending != PEND_MAX);
    assign o_req_ready = w_req_ready;
    assign o_rsp_valid = (r_state == SLOT_FULL);
    assign o_taken     = r_taken;
    assign o_flags     = r_flags;
    assign o_pending   = r_pending;
    assign o_err       = r_err;

endmodule

// File: tb/tb_cond_check_unit.sv
// Directed, table-driven bench for cond_check_unit; honours COND_BYPASS_EN when defined.
module tb_cond_check_unit;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_cmp_issue;
    logic       o_cmp_ready;
    logic       i_flags_valid;
    logic       i_n, i_z, i_c, i_v;
    logic       i_req_valid;
    logic       o_req_ready;
    logic [3:0] i_cond;
    logic       o_rsp_valid;
    logic       i_rsp_ready;
    logic       o_taken;
    logic [3:0] o_flags;
    logic [1:0] o_pending;
    logic       o_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t vecs[$];
    logic [0:0] exp_q[$];

    cond_check_unit #(.PEND_W(2)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_cmp_issue   (i_cmp_issue),
        .o_cmp_ready   (o_cmp_ready),
        .i_flags_valid (i_flags_valid),
        .i_n           (i_n),
        .i_z           (i_z),
        .i_c           (i_c),
        .i_v           (i_v),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_cond        (i_cond),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_taken       (o_taken),
        .o_flags       (o_flags),
        .o_pending     (o_pending),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Outputs are sampled and inputs changed 1 time unit after each rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        i_cmp_issue = 1'b1;
        tick();
        i_cmp_issue   = 1'b0;
        i_flags_valid = 1'b1;
        {i_n, i_z, i_c, i_v} = f;
        tick();
        i_flags_valid = 1'b0;
        check("flags_loaded", o_flags, f);
    endtask

    task automatic query(input logic [3:0] cond, input logic exp);
        i_req_valid = 1'b1;
        i_cond      = cond;
        i_rsp_ready = 1'b1;
        #1;
        check("req_ready_idle", o_req_ready, 1'b1);
        tick();
        i_req_valid = 1'b0;
        check("rsp_valid", o_rsp_valid, 1'b1);
        check($sformatf("taken_c%0h_f%0h", cond, o_flags), o_taken, exp);
        tick();
    endtask

    initial begin
        logic [3:0] cur_flags;
        i_rst = 1'b1; i_cmp_issue = 1'b0; i_flags_valid = 1'b0;
        i_n = 1'b0; i_z = 1'b0; i_c = 1'b0; i_v = 1'b0;
        i_req_valid = 1'b0; i_cond = 4'h0; i_rsp_ready = 1'b1;

        // {flags NZCV, cond, expected taken}
        vecs.push_back('{4'b0110, 4'h0, 1'b1});
        vecs.push_back('{4'b0110, 4'h1, 1'b0});
        vecs.push_back('{4'b0110, 4'h2, 1'b1});
        vecs.push_back('{4'b0110, 4'h3, 1'b0});
        vecs.push_back('{4'b0110, 4'h8, 1'b0});
        vecs.push_back('{4'b0110, 4'h9, 1'b1});
        vecs.push_back('{4'b0110, 4'hA, 1'b1});
        vecs.push_back('{4'b0110, 4'hC, 1'b0});
        vecs.push_back('{4'b1000, 4'h0, 1'b0});
        vecs.push_back('{4'b1000, 4'h1, 1'b1});
        vecs.push_back('{4'b1000, 4'h2, 1'b0});
        vecs.push_back('{4'b1000, 4'h3, 1'b1});
        vecs.push_back('{4'b1000, 4'h4, 1'b1});
        vecs.push_back('{4'b1000, 4'h5, 1'b0});
        vecs.push_back('{4'b1000, 4'h6, 1'b0});
        vecs.push_back('{4'b1000, 4'h7, 1'b1});
        vecs.push_back('{4'b1000, 4'h8, 1'b0});
        vecs.push_back('{4'b1000, 4'h9, 1'b1});
        vecs.push_back('{4'b1000, 4'hA, 1'b0});
        vecs.push_back('{4'b1000, 4'hB, 1'b1});
        vecs.push_back('{4'b1000, 4'hC, 1'b0});
        vecs.push_back('{4'b1000, 4'hD, 1'b1});
        vecs.push_back('{4'b1000, 4'hE, 1'b1});
        vecs.push_back('{4'b1000, 4'hF, 1'b0});
        vecs.push_back('{4'b0011, 4'h6, 1'b1});
        vecs.push_back('{4'b0011, 4'hA, 1'b0});
        vecs.push_back('{4'b0011, 4'hB, 1'b1});
        vecs.push_back('{4'b0011, 4'h8, 1'b1});
        vecs.push_back('{4'b0011, 4'hC, 1'b0});

        // Reset state
        tick(); tick();
        i_rst = 1'b0;
        check("rst_flags", o_flags, 4'b0000);
        check("rst_pending", o_pending, 2'd0);
        check("rst_rsp_valid", o_rsp_valid, 1'b0);
        check("rst_taken", o_taken, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_cmp_ready", o_cmp_ready, 1'b1);

        // T1/T2: table sweep
        cur_flags = 4'b0000;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].flags != cur_flags) begin
                load_flags(vecs[i].flags);
                cur_flags = vecs[i].flags;
            end
            query(vecs[i].cond, vecs[i].exp);
        end
        check("no_err_after_sweep", o_err, 1'b0);

        // T3: query stalls while a compare is in flight (flags now 0011, Z=0)
        i_cmp_issue = 1'b1;
        tick();
        i_cmp_issue = 1'b0;
        check("t3_pending1", o_pending, 2'd1);
        i_req_valid = 1'b1; i_cond = 4'h0; i_rsp_ready = 1'b1;
        #1;
        check("t3_stall_a", o_req_ready, 1'b0);
        tick();
        check("t3_stall_b", o_req_ready, 1'b0);
        i_flags_valid = 1'b1;
        {i_n, i_z, i_c, i_v} = 4'b0100;
        #1;
`ifdef COND_BYPASS_EN
        check("t3_bypass_ready", o_req_ready, 1'b1);
        tick();
        i_flags_valid = 1'b0;
        i_req_valid   = 1'b0;
        check("t3_bypass_rsp", o_rsp_valid, 1'b1);
        check("t3_bypass_taken", o_taken, 1'b1);
`else
        check("t3_no_bypass", o_req_ready, 1'b0);
        tick();
        i_flags_valid = 1'b0;
        #1;
        check("t3_ready_after", o_req_ready, 1'b1);
        tick();
        i_req_valid = 1'b0;
        check("t3_rsp", o_rsp_valid, 1'b1);
        check("t3_taken", o_taken, 1'b1);
`endif
        check("t3_flags", o_flags, 4'b0100);
        tick();

        // T4: consumer backpressure then back-to-back drain (flags Z=1)
        i_req_valid = 1'b1; i_cond = 4'h0; i_rsp_ready = 1'b0;
        tick();
        i_cond = 4'h1;
        for (int k = 0; k < 3; k++) begin
            check("t4_hold_valid", o_rsp_valid, 1'b1);
            check("t4_hold_taken", o_taken, 1'b1);
            #1;
            check("t4_hold_req_ready", o_req_ready, 1'b0);
            tick();
        end
        i_rsp_ready = 1'b1;
        #1;
        check("t4_ready_on_release", o_req_ready, 1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int k = 0; k < 4; k++) begin
            i_cond = k[0] ? 4'h0 : 4'h1;
            tick();
            check("t4_b2b_valid", o_rsp_valid, 1'b1);
            if (exp_q.size() > 0) check("t4_b2b_taken", o_taken, exp_q.pop_front());
        end
        i_req_valid = 1'b0;
        tick();
        check("t4_empty", o_rsp_valid, 1'b0);

        // T5: pending saturation and stray result error
        i_cmp_issue = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("t5_pending_up", o_pending, k);
        end
        check("t5_cmp_ready_low", o_cmp_ready, 1'b0);
        tick();
        check("t5_ignored_issue", o_pending, 2'd3);
        i_cmp_issue   = 1'b0;
        i_flags_valid = 1'b1;
        {i_n, i_z, i_c, i_v} = 4'b1011;
        for (int k = 2; k >= 0; k--) begin
            tick();
            check("t5_pending_down", o_pending, k);
        end
        check("t5_flags", o_flags, 4'b1011);
        check("t5_err_clear", o_err, 1'b0);
        {i_n, i_z, i_c, i_v} = 4'b0101;
        tick();
        i_flags_valid = 1'b0;
        check("t5_err_set", o_err, 1'b1);
        check("t5_flags_kept", o_flags, 4'b1011);
        check("t5_pending_zero", o_pending, 2'd0);
        tick();
        check("t5_err_sticky", o_err, 1'b1);

        // T6: reset while FULL with two compares outstanding
        i_req_valid = 1'b1; i_cond = 4'hE; i_rsp_ready = 1'b0;
        tick();
        i_req_valid = 1'b0;
        i_cmp_issue = 1'b1;
        tick(); tick();
        i_cmp_issue = 1'b0;
        check("t6_pre_full", o_rsp_valid, 1'b1);
        check("t6_pre_taken", o_taken, 1'b1);
        check("t6_pre_pending", o_pending, 2'd2);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("t6_flags", o_flags, 4'b0000);
        check("t6_pending", o_pending, 2'd0);
        check("t6_rsp_valid", o_rsp_valid, 1'b0);
        check("t6_taken", o_taken, 1'b0);
        check("t6_err", o_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
